poll_result_unit: RTL and testbench

End-of-poll results stage sitting directly downstream of the voting machine's vote logger. On a close-poll request it snapshots the four 8-bit candidate tallies and scans them sequentially, one candidate per clock. It then presents winner index, winner count, total votes, tie and no-vote flags behind a valid/ack handshake for the display/announcement logic.

---
 rtl/poll_result_unit.sv | 134 +++++++++++++
 tb/tb_poll_result_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/poll_result_unit.sv
`default_nettype none
// ============================================================================
// Module      : poll_result_unit
// Description : End-of-poll results stage. Snapshots four tallies, scans one
//               candidate per clock, presents winner/total/tie behind valid/ack.
// Revision    : 1.0  initial release
// ============================================================================
module poll_result_unit (
    input  logic       clock,
    input  logic       reset,
    input  logic       close_poll,
    input  logic [7:0] cand1_votes,
    input  logic [7:0] cand2_votes,
    input  logic [7:0] cand3_votes,
    input  logic [7:0] cand4_votes,
    input  logic       result_ack,
    output logic       busy,
    output logic       result_valid,
    output logic [1:0] winner_id,
    output logic [7:0] winner_votes,
    output logic [9:0] total_votes,
    output logic       tie,
    output logic       no_votes
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0] state;
    logic [7:0] snap [4];
    logic [1:0] idx;
    logic [7:0] best;
    logic [1:0] best_id;
    logic [9:0] sum;
    logic       tie_run;

    logic [7:0] cur;
    logic [7:0] nxt_best;
    logic [1:0] nxt_id;
    logic [9:0] nxt_sum;
    logic       nxt_tie;

    // Running max/sum update for the candidate at idx; lowest index keeps ties.
    always_comb begin
        cur      = snap[idx];
        nxt_best = best;
        nxt_id   = best_id;
        nxt_sum  = sum + {2'b00, cur};
        nxt_tie  = tie_run;
        if (idx == 2'd0) begin
            nxt_best = cur;
            nxt_id   = 2'd0;
            nxt_sum  = {2'b00, cur};
            nxt_tie  = 1'b0;
        end else if (cur > best) begin
            nxt_best = cur;
            nxt_id   = idx;
            nxt_tie  = 1'b0;
        end else if (cur == best) begin
            nxt_tie  = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            snap[0]      <= 8'd0;
            snap[1]      <= 8'd0;
            snap[2]      <= 8'd0;
            snap[3]      <= 8'd0;
            idx          <= 2'd0;
            best         <= 8'd0;
            best_id      <= 2'd0;
            sum          <= 10'd0;
            tie_run      <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            winner_id    <= 2'd0;
            winner_votes <= 8'd0;
            total_votes  <= 10'd0;
            tie          <= 1'b0;
            no_votes     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (close_poll) begin
                        snap[0] <= cand1_votes;
                        snap[1] <= cand2_votes;
                        snap[2] <= cand3_votes;
                        snap[3] <= cand4_votes;
                        idx     <= 2'd0;
                        best    <= 8'd0;
                        best_id <= 2'd0;
                        sum     <= 10'd0;
                        tie_run <= 1'b0;
                        busy    <= 1'b1;
                        state   <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    best    <= nxt_best;
                    best_id <= nxt_id;
                    sum     <= nxt_sum;
                    tie_run <= nxt_tie;
                    idx     <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        winner_id    <= nxt_id;
                        winner_votes <= nxt_best;
                        total_votes  <= nxt_sum;
                        no_votes     <= (nxt_sum == 10'd0);
                        tie          <= nxt_tie & (nxt_sum != 10'd0);
                        result_valid <= 1'b1;
                        state        <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (result_ack) begin
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: begin
                    result_valid <= 1'b0;
                    busy         <= 1'b0;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_poll_result_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_poll_result_unit
// Description : Directed + randomized checks of poll_result_unit against a
//               behavioural max/sum model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_poll_result_unit;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       close_poll = 1'b0;
    logic [7:0] cand1_votes = 8'd0;
    logic [7:0] cand2_votes = 8'd0;
    logic [7:0] cand3_votes = 8'd0;
    logic [7:0] cand4_votes = 8'd0;
    logic       result_ack = 1'b0;
    logic       busy;
    logic       result_valid;
    logic [1:0] winner_id;
    logic [7:0] winner_votes;
    logic [9:0] total_votes;
    logic       tie;
    logic       no_votes;

    int checks = 0;
    int errors = 0;

    int exp_id, exp_best, exp_sum, exp_tie, exp_nv;

    poll_result_unit dut (
        .clock        (clock),
        .reset        (reset),
        .close_poll   (close_poll),
        .cand1_votes  (cand1_votes),
        .cand2_votes  (cand2_votes),
        .cand3_votes  (cand3_votes),
        .cand4_votes  (cand4_votes),
        .result_ack   (result_ack),
        .busy         (busy),
        .result_valid (result_valid),
        .winner_id    (winner_id),
        .winner_votes (winner_votes),
        .total_votes  (total_votes),
        .tie          (tie),
        .no_votes     (no_votes)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: maximum, first index holding it, how many share it, plain sum.
    task automatic model(input int a, input int b, input int c, input int d);
        int v[4];
        int mx, cnt;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        mx = 0; cnt = 0; exp_sum = 0; exp_id = -1;
        for (int i = 0; i < 4; i++) begin
            exp_sum += v[i];
            if (v[i] > mx) mx = v[i];
        end
        for (int i = 0; i < 4; i++) begin
            if (v[i] == mx) begin
                cnt++;
                if (exp_id < 0) exp_id = i;
            end
        end
        exp_best = mx;
        exp_nv   = (exp_sum == 0) ? 1 : 0;
        exp_tie  = (cnt > 1 && exp_nv == 0) ? 1 : 0;
    endtask

    task automatic chk_fields(input string tag);
        chk({tag, ".winner_id"},    32'(winner_id),    32'(exp_id));
        chk({tag, ".winner_votes"}, 32'(winner_votes), 32'(exp_best));
        chk({tag, ".total_votes"},  32'(total_votes),  32'(exp_sum));
        chk({tag, ".tie"},          32'(tie),          32'(exp_tie));
        chk({tag, ".no_votes"},     32'(no_votes),     32'(exp_nv));
    endtask

    // Runs one poll from the close_poll edge through result_valid rising.
    task automatic run_poll(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d,
                            input bit mid_pulse, input bit change4);
        model(int'(a), int'(b), int'(c), int'(d));
        cand1_votes = a; cand2_votes = b; cand3_votes = c; cand4_votes = d;
        close_poll = 1'b1;
        tick();
        close_poll = 1'b0;
        chk({tag, ".busy_e0"},  32'(busy), 32'd1);
        chk({tag, ".valid_e0"}, 32'(result_valid), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            if (change4 && k == 1) cand4_votes = 8'd200;
            if (mid_pulse && k == 2) close_poll = 1'b1;
            tick();
            close_poll = 1'b0;
            chk({tag, ".busy_scan"},  32'(busy), 32'd1);
            chk({tag, ".valid_scan"}, 32'(result_valid), 32'd0);
        end
        tick();
        chk({tag, ".valid_e4"}, 32'(result_valid), 32'd1);
        chk({tag, ".busy_e4"},  32'(busy), 32'd1);
        chk_fields(tag);
    endtask

    task automatic do_ack(input string tag);
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        chk({tag, ".valid_ack"}, 32'(result_valid), 32'd0);
        chk({tag, ".busy_ack"},  32'(busy), 32'd0);
        chk({tag, ".hold_total"}, 32'(total_votes), 32'(exp_sum));
    endtask

    initial begin
        logic [7:0] ra, rb, rc, rd;

        tick();
        tick();
        reset = 1'b0;
        chk("rst.busy",  32'(busy), 32'd0);
        chk("rst.valid", 32'(result_valid), 32'd0);
        exp_id = 0; exp_best = 0; exp_sum = 0; exp_tie = 0; exp_nv = 0;
        chk_fields("rst");

        // ack outside DONE is harmless
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        chk("idle_ack.busy", 32'(busy), 32'd0);

        run_poll("basic", 8'd3, 8'd7, 8'd2, 8'd5, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("hold.valid", 32'(result_valid), 32'd1);
            chk("hold.busy",  32'(busy), 32'd1);
            chk_fields("hold");
        end
        do_ack("basic");

        run_poll("tie9", 8'd9, 8'd4, 8'd9, 8'd9, 1'b0, 1'b0);
        do_ack("tie9");
        run_poll("zero", 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        do_ack("zero");
        run_poll("full", 8'd255, 8'd255, 8'd255, 8'd255, 1'b0, 1'b0);
        do_ack("full");
        run_poll("last", 8'd0, 8'd0, 8'd0, 8'd255, 1'b0, 1'b0);
        do_ack("last");

        run_poll("snap", 8'd3, 8'd7, 8'd2, 8'd5, 1'b0, 1'b1);
        do_ack("snap");

        // pulse during SCAN must not queue another computation
        run_poll("midpulse", 8'd10, 8'd20, 8'd30, 8'd5, 1'b1, 1'b0);
        do_ack("midpulse");
        tick();
        chk("midpulse.idle", 32'(busy), 32'd0);

        // ack + close together: back to IDLE, then close held starts next edge
        run_poll("ackclose", 8'd1, 8'd1, 8'd0, 8'd0, 1'b0, 1'b0);
        result_ack = 1'b1;
        close_poll = 1'b1;
        tick();
        result_ack = 1'b0;
        chk("ackclose.busy",  32'(busy), 32'd0);
        chk("ackclose.valid", 32'(result_valid), 32'd0);
        tick();
        close_poll = 1'b0;
        chk("held.busy_restart", 32'(busy), 32'd1);
        for (int k = 0; k < 4; k++) tick();
        chk("held.valid", 32'(result_valid), 32'd1);
        chk_fields("held");
        do_ack("held");

        // reset at the second SCAN edge aborts the computation
        cand1_votes = 8'd50; cand2_votes = 8'd60; cand3_votes = 8'd70; cand4_votes = 8'd80;
        close_poll = 1'b1;
        tick();
        close_poll = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst.busy",  32'(busy), 32'd0);
        chk("midrst.valid", 32'(result_valid), 32'd0);
        exp_id = 0; exp_best = 0; exp_sum = 0; exp_tie = 0; exp_nv = 0;
        chk_fields("midrst");
        tick();
        chk("midrst.stay_idle", 32'(busy), 32'd0);
        run_poll("post_rst", 8'd1, 8'd2, 8'd3, 8'd4, 1'b0, 1'b0);
        do_ack("post_rst");

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                ra = 8'($urandom_range(0, 2)); rb = 8'($urandom_range(0, 2));
                rc = 8'($urandom_range(0, 2)); rd = 8'($urandom_range(0, 2));
            end else begin
                ra = 8'($urandom); rb = 8'($urandom);
                rc = 8'($urandom); rd = 8'($urandom);
            end
            run_poll("rand", ra, rb, rc, rd, 1'b0, 1'b0);
            do_ack("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
